affine_host: RTL
================

# affine_host

Host-side sequencer that drives one affine core run per transaction. It takes an operand on a valid/ready input stream, holds it on the core's external data input and releases the core from reset. When the core reports halt it reads both accumulator results back through the core's shared external data output, then presents them on a valid/ready output stream. It sits between the system fabric and the core, and is the only block that drives the core's reset and samples its result port.

## Interface
Parameters:
- N, 8: datapath width; must equal the core's N.
- TIMEOUT, 15: maximum RUN cycles before an abort.
- CW, $clog2(TIMEOUT+1): localparam, cycle-counter width.

Ports:
- clk_i  in  1  sole clock; same clock as the core.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  host idle and able to accept an operand.
- in_x_i  in  N  operand.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_r1_o  out  N  acc1 result.
- out_r2_o  out  N  acc2 result.
- out_cycles_o  out  CW  RUN cycles counted for this transaction.
- out_err_o  out  1  run aborted by timeout, or halt reported with prog_addr ≠ 2'b11.
- core_n_rst_o  out  1  active-low reset to the core; registered.
- core_data_o  out  N  to the core's ext_data_i.
- core_data_i  in  N  from the core's ext_data_o: acc1 while the core is out of reset, acc2 while it is held in reset.
- core_prog_addr_i  in  2  core program address.
- core_halt_i  in  1  core halt.

## Operation
- FSM states: IDLE, RUN, CAP2, OUT.
- IDLE:
  - in_ready_o=1, core_n_rst_o=0.
  - On in_valid_i&&in_ready_o: latch in_x_i into the operand register, set core_n_rst_o<=1, clear the counter, go to RUN.
- RUN:
  - The counter increments every cycle and saturates at TIMEOUT.
  - On core_halt_i=1:
    - Capture core_data_i into r1. This is acc1, because the core is still out of reset.
    - Set err<=(core_prog_addr_i!=2'b11).
    - Set core_n_rst_o<=0 and go to CAP2.
  - On timeout (counter==TIMEOUT and no halt): set r1<=0, err<=1, core_n_rst_o<=0, go to CAP2.
- CAP2:
  - The core is now held in reset, so its output mux selects acc2.
  - Capture core_data_i into r2. Set out_valid_o<=1 and go to OUT.
- OUT:
  - Hold out_valid_o and all result outputs stable until out_ready_i=1.
  - On acceptance: out_valid_o<=0, go to IDLE.
- core_data_o equals the operand register in every state. It keeps the last operand after a run.
- out_cycles_o is the counter value frozen at the RUN exit edge.
- Halt and timeout in the same cycle: halt wins and err comes only from the prog_addr check.

## Timing
- Values after rst_i, all taking effect on the next edge:
  - state=IDLE, in_ready_o=1, out_valid_o=0.
  - out_r1_o=0, out_r2_o=0, out_cycles_o=0, out_err_o=0.
  - core_n_rst_o=0, core_data_o=0.
- rst_i mid-run forces the above at the next edge, so the core is re-held in reset. Any partial result is discarded and out_valid_o is never raised for it.
- rst_i has priority over every transition, including a simultaneous OUT handshake.
- Edge E0 is input acceptance; the core leaves reset from E0.
- The halt-sampling edge Eh captures r1; r2 is captured at Eh+1.
- out_valid_o is high from Eh+1. Minimum in-to-out latency is halt latency + 1.
- A new operand is accepted no earlier than the cycle after the output handshake, because in_ready_o is 0 in OUT.
- All outputs are registered except in_ready_o, which is decoded from state.
- Counter width rule: the count never wraps; it saturates at TIMEOUT.

## Configuration
- AFFINE_HOST_TIMEOUT_EN defined:
  - The watchdog is compiled in and TIMEOUT applies as described.
- AFFINE_HOST_TIMEOUT_EN undefined:
  - The watchdog is removed and RUN waits indefinitely for core_halt_i.
  - The counter still saturates at its maximum value.
  - out_err_o reflects only the prog_addr check.

## Test plan
- Stub core halts 4 cycles after release with prog_addr=3, acc1=0x5A, acc2=0xC3; operand x=0x11.
  - Expect core_data_o=0x11 throughout the run.
  - Expect out_r1_o=0x5A, out_r2_o=0xC3, out_cycles_o=4, out_err_o=0.
- Same run with out_ready_i held low for 10 cycles.
  - Outputs stay stable and in_ready_o=0 throughout; after acceptance, in_ready_o=1 on the next cycle.
- Stub never halts (AFFINE_HOST_TIMEOUT_EN defined, TIMEOUT=15).
  - Expect out_valid_o with out_err_o=1, out_r1_o=0 and out_cycles_o=15.
  - Expect core_n_rst_o=0 after the abort.
- Stub halts with prog_addr=1.
  - Expect out_err_o=1 with acc values captured normally.
- rst_i pulsed two cycles into RUN.
  - Expect core_n_rst_o=0 and in_ready_o=1 on the next edge, and no out_valid_o pulse.
- Back-to-back operands 0x01 then 0x02 with out_ready_i tied high.
  - Expect two results in order, with exactly one IDLE cycle between out acceptance and the next in acceptance.

Source files
------------

// File: rtl/affine_host_if.sv
// rtl/affine_host_if.sv - operand/result streams and core control bundle for affine_host
interface affine_host_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic [N-1:0]  in_x_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [N-1:0]  out_r1_o;
    logic [N-1:0]  out_r2_o;
    logic [CW-1:0] out_cycles_o;
    logic          out_err_o;
    logic          core_n_rst_o;
    logic [N-1:0]  core_data_o;
    logic [N-1:0]  core_data_i;
    logic [1:0]    core_prog_addr_i;
    logic          core_halt_i;

    modport slave (
        input  in_valid_i, in_x_i, out_ready_i, core_data_i, core_prog_addr_i, core_halt_i,
        output in_ready_o, out_valid_o, out_r1_o, out_r2_o, out_cycles_o, out_err_o,
        output core_n_rst_o, core_data_o
    );

    modport master (
        output in_valid_i, in_x_i, out_ready_i, core_data_i, core_prog_addr_i, core_halt_i,
        input  in_ready_o, out_valid_o, out_r1_o, out_r2_o, out_cycles_o, out_err_o,
        input  core_n_rst_o, core_data_o
    );
endinterface

// File: rtl/affine_host.sv
// rtl/affine_host.sv - sequencer running one affine core pass per operand and reading back acc1/acc2
// Optional watchdog: define AFFINE_HOST_TIMEOUT_EN to abort runs longer than TIMEOUT cycles.
module affine_host #(
    parameter int N       = 8,
    parameter int TIMEOUT = 15,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    affine_host_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, CAP2, OUT} state_t;

`ifdef AFFINE_HOST_TIMEOUT_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
`else
    localparam logic [CW-1:0] CNT_MAX = '1;
`endif

    state_t        state;
    logic [N-1:0]  x_q;
    logic [N-1:0]  r1_q;
    logic [N-1:0]  r2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cycles_q;
    logic          err_q;
    logic          valid_q;
    logic          core_n_rst_q;
    logic [CW-1:0] cnt_next;
    logic          timeout_hit;

    assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef AFFINE_HOST_TIMEOUT_EN
    assign timeout_hit = (cnt_q == CNT_MAX);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            x_q          <= '0;
            r1_q         <= '0;
            r2_q         <= '0;
            cnt_q        <= '0;
            cycles_q     <= '0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            core_n_rst_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        x_q          <= bus.in_x_i;
                        core_n_rst_q <= 1'b1;
                        cnt_q        <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_next;
                    // Halt beats the watchdog when both land on the same edge.
                    if (bus.core_halt_i) begin
                        r1_q         <= bus.core_data_i;
                        err_q        <= (bus.core_prog_addr_i != 2'b11);
                        cycles_q     <= cnt_next;
                        core_n_rst_q <= 1'b0;
                        state        <= CAP2;
                    end else if (timeout_hit) begin
                        r1_q         <= '0;
                        err_q        <= 1'b1;
                        cycles_q     <= cnt_next;
                        core_n_rst_q <= 1'b0;
                        state        <= CAP2;
                    end
                end
                CAP2: begin
                    // Core now in reset: its shared output port shows acc2.
                    r2_q    <= bus.core_data_i;
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (bus.out_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o   = (state == IDLE);
    assign bus.out_valid_o  = valid_q;
    assign bus.out_r1_o     = r1_q;
    assign bus.out_r2_o     = r2_q;
    assign bus.out_cycles_o = cycles_q;
    assign bus.out_err_o    = err_q;
    assign bus.core_n_rst_o = core_n_rst_q;
    assign bus.core_data_o  = x_q;
endmodule
